// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Responding end of the core's data-memory port. It accepts one load/store
// request at a time, waits LATENCY cycles, performs the array access on the
// edge that enters RESP, and then holds the response until the requester
// takes it. The storage array belongs to this block and is not cleared by
// reset.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. Once raised, rsp_valid, rsp_rdata and rsp_err
// stay stable until that edge. req_ready is high only in IDLE, so at most
// one access is in flight.
//
// Optional feature macro: DMEM_ERR_EN
//   defined   : req_addr >= DEPTH returns rsp_err=1, no write, rsp_rdata=0
//   undefined : address wraps modulo DEPTH, rsp_err tied 0
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_load, req_store      access type (both set = store)
//   req_addr                 word address
//   req_mask                 byte-lane write enables
//   req_wdata                lane-aligned store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                full read word (0 for stores and no-ops)
//   rsp_err                  access error
//   dbg_state                FSM state: 0=IDLE 1=WAIT 2=RESP
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_mask,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];

  // The access operands come straight from the request port when the
  // access edge is also the accept edge (LATENCY=0), otherwise from the
  // captured copy.
  logic              acc_load, acc_store, acc_err, access, mem_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_mask;
  logic [31:0]       acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              addr_unused;

  always_comb begin
    if (state_q == IDLE) begin
      acc_load  = req_load;
      acc_store = req_store;
      acc_addr  = req_addr;
      acc_mask  = req_mask;
      acc_wdata = req_wdata;
    end else begin
      acc_load  = load_q;
      acc_store = store_q;
      acc_addr  = addr_q;
      acc_mask  = mask_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx     = acc_addr[IDX_W-1:0];
  assign addr_unused = ^acc_addr;

`ifdef DMEM_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  assign acc_err = ({1'b0, acc_addr} >= DEPTH_EXT);
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    store_d   = store_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    access    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_d  = req_load;
          store_d = req_store;
          addr_d  = req_addr;
          mask_d  = req_mask;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = RESP;
            access  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Store wins when both type bits are set, so only a pure load reads.
    if (access) begin
      err_d   = acc_err;
      rdata_d = (acc_load && !acc_store && !acc_err) ? mem_q[acc_idx] : 32'd0;
    end
  end

  // A reset on the would-be access edge drops the access entirely.
  assign mem_we = access && acc_store && !acc_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule
